display_scheduler: RTL

- Arbitrates the shared four-digit seven-segment display between several requesters, for example alert, timer and score.
- Selects one requester and drives its 11-bit value into the existing binary-to-7-seg display block. Also drives a blank control for display-off and blink effects.
- Enforces a minimum dwell time per grant so the display never flickers between sources.

---
 rtl/display_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/display_scheduler.sv
// Priority arbiter for the shared seven-segment display: picks one requester,
// holds it for a minimum dwell time and generates the blank/blink control.
module display_scheduler #(
  parameter int N_REQ        = 3,
  parameter int VALUE_W      = 11,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*VALUE_W-1:0]   values,
  input  logic [N_REQ-1:0]           blink_en,
  output logic [N_REQ-1:0]           grant,
  output logic [VALUE_W-1:0]         value_out,
  output logic                       blank_out,
  output logic                       busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DW-1:0] HOLD_M1  = DW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_M1 = BW'(BLINK_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t             r_state, w_state;
  logic [N_REQ-1:0]   r_grant, w_grant;
  logic [IW-1:0]      r_idx, w_idx;
  logic [VALUE_W-1:0] r_value, w_value;
  logic               r_blank, w_blank;
  logic [DW-1:0]      r_dwell, w_dwell;
  logic [BW-1:0]      r_bcnt, w_bcnt;
  logic               r_phase, w_phase;
  logic [IW-1:0]      w_low_idx;
  logic               w_any;
  logic               w_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_value <= '0;
      r_blank <= 1'b1;
      r_dwell <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_idx   <= w_idx;
      r_value <= w_value;
      r_blank <= w_blank;
      r_dwell <= w_dwell;
      r_bcnt  <= w_bcnt;
      r_phase <= w_phase;
    end
  end

  always_comb begin
    w_any     = |req;
    w_low_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) w_low_idx = IW'(i);
    end

    w_state = r_state;
    w_grant = r_grant;
    w_idx   = r_idx;
    w_value = r_value;
    w_blank = r_blank;
    w_dwell = r_dwell;
    w_bcnt  = r_bcnt;
    w_phase = r_phase;
    w_new   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_new = 1'b1;
        end else begin
          w_grant = '0;
          w_blank = 1'b1;
        end
      end
      SHOW: begin
        // Staying with the current owner: still dwelling, or it re-won arbitration
        if (r_dwell != '0 || (w_any && w_low_idx == r_idx)) begin
          w_dwell = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
          if (req[r_idx]) w_value = values[int'(r_idx)*VALUE_W +: VALUE_W];
          if (blink_en[r_idx]) begin
            if (r_bcnt == BLINK_M1) begin
              w_bcnt  = '0;
              w_phase = ~r_phase;
            end else begin
              w_bcnt = r_bcnt + 1'b1;
            end
            w_blank = w_phase;
          end else begin
            w_blank = 1'b0;
          end
        end else if (w_any) begin
          w_new = 1'b1;
        end else begin
          w_state = IDLE;
          w_grant = '0;
          w_blank = 1'b1;
          w_dwell = '0;
          w_bcnt  = '0;
          w_phase = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_new) begin
      w_state            = SHOW;
      w_idx              = w_low_idx;
      w_grant            = '0;
      w_grant[w_low_idx] = 1'b1;
      w_value            = values[int'(w_low_idx)*VALUE_W +: VALUE_W];
      w_blank            = 1'b0;
      w_dwell            = HOLD_M1;
      w_bcnt             = '0;
      w_phase            = 1'b0;
    end
  end

  assign grant     = r_grant;
  assign value_out = r_value;
  assign blank_out = r_blank;
  assign busy      = (r_state == SHOW);

endmodule
